// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write/read channel arbiters.
// Holds the arbiter state encoding, grant codes and the beat counter width helper.
package axi_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One extra bit so the counter can hold MAX_BEATS itself.
  function automatic int beat_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/axi_arb_pick.sv
// Two-input priority picker: one-hot grant from requests; ptr=0 favours m0 on a tie,
// ptr=1 favours m1. Also used by the read-channel arbiter.
module axi_arb_pick
  import axi_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   ptr,
  output logic [NUM_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = GRANT_NONE;
    if (req[0] && (!req[1] || !ptr)) begin
      gnt = GRANT_M0;
    end else if (req[1]) begin
      gnt = GRANT_M1;
    end
  end

endmodule

// File: rtl/axi_arbiter_w.sv
// Write-channel arbiter: shares one AW/W/B path between two masters, holding the grant
// from AW through WLAST to the B handshake. Macro AXI_ARB_RR_EN selects round-robin ties.
module axi_arbiter_w
  import axi_arb_pkg::*;
#(
  parameter int ID_WIDTH  = 8,
  parameter int MAX_BEATS = 256
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           m0_AWVALID,
  input  logic                           m1_AWVALID,
  output logic                           m0_AWREADY,
  output logic                           m1_AWREADY,
  input  logic [ID_WIDTH-1:0]            m0_AWID,
  input  logic [ID_WIDTH-1:0]            m1_AWID,
  input  logic                           m0_WVALID,
  input  logic                           m1_WVALID,
  input  logic                           m0_WLAST,
  input  logic                           m1_WLAST,
  output logic                           m0_WREADY,
  output logic                           m1_WREADY,
  output logic                           m0_BVALID,
  output logic                           m1_BVALID,
  input  logic                           m0_BREADY,
  input  logic                           m1_BREADY,
  output logic                           s_AWVALID,
  input  logic                           s_AWREADY,
  output logic                           s_WVALID,
  output logic                           s_WLAST,
  input  logic                           s_WREADY,
  input  logic                           s_BVALID,
  input  logic [ID_WIDTH-1:0]            s_BID,
  output logic                           s_BREADY,
  output logic [1:0]                     grant,
  output logic                           busy,
  output logic [beat_w(MAX_BEATS)-1:0]   beat_cnt
);

  localparam int BW = beat_w(MAX_BEATS);

  arb_state_t          state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [1:0]          pick_gnt;
  logic                pick_ptr;

`ifdef AXI_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 1'b0;
`endif

  axi_arb_pick u_pick (
    .req ({m1_AWVALID, m0_AWVALID}),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  logic in_aw, in_w, in_b, g0, g1;
  assign in_aw = (state_q == ST_AW);
  assign in_w  = (state_q == ST_W);
  assign in_b  = (state_q == ST_B);
  assign g0    = grant_q[0];
  assign g1    = grant_q[1];

  // All gating is from registered state, so no READY input reaches a VALID output.
  assign s_AWVALID  = in_aw & ((g0 & m0_AWVALID) | (g1 & m1_AWVALID));
  assign m0_AWREADY = in_aw & g0 & s_AWREADY;
  assign m1_AWREADY = in_aw & g1 & s_AWREADY;
  assign s_WVALID   = in_w & ((g0 & m0_WVALID) | (g1 & m1_WVALID));
  assign s_WLAST    = in_w & ((g0 & m0_WLAST) | (g1 & m1_WLAST));
  assign m0_WREADY  = in_w & g0 & s_WREADY;
  assign m1_WREADY  = in_w & g1 & s_WREADY;
  assign m0_BVALID  = in_b & g0 & s_BVALID;
  assign m1_BVALID  = in_b & g1 & s_BVALID;
  assign s_BREADY   = in_b & ((g0 & m0_BREADY) | (g1 & m1_BREADY));

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign beat_cnt = beat_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    awid_d  = awid_q;
`ifdef AXI_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_gnt != GRANT_NONE) begin
          grant_d = pick_gnt;
          state_d = ST_AW;
        end
      end
      // A withdrawn AWVALID simply stalls here; the grant is kept.
      ST_AW: begin
        if (s_AWVALID && s_AWREADY) begin
          awid_d  = g1 ? m1_AWID : m0_AWID;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (s_WVALID && s_WREADY) begin
          if (beat_q != BW'(MAX_BEATS)) begin
            beat_d = beat_q + BW'(1);
          end
          if (s_WLAST) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (s_BVALID && s_BREADY) begin
          state_d = ST_IDLE;
          grant_d = GRANT_NONE;
          beat_d  = '0;
`ifdef AXI_ARB_RR_EN
          ptr_d   = g0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GRANT_NONE;
        beat_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_NONE;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      awid_q  <= '0;
`ifdef AXI_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      beat_q  <= beat_d;
      awid_q  <= awid_d;
`ifdef AXI_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // The returned BID must belong to the burst that owns the write path.
  a_bid_match : assert property (@(posedge ACLK) disable iff (ARESET)
    (in_b && s_BVALID) |-> (s_BID == awid_q));

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Scoreboard bench for axi_arbiter_w: directed bursts push expected grant/beat/B events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_axi_arbiter_w;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       av [2];
  logic       aw_rdy [2];
  logic [7:0] aid [2];
  logic       wv [2];
  logic       wl [2];
  logic       w_rdy [2];
  logic       b_vld [2];
  logic       br [2];
  logic       s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [7:0] s_bid;
  logic [1:0] grant;
  logic       busy;
  logic [8:0] beat_cnt;

  always #5 clk = ~clk;

  axi_arbiter_w #(.ID_WIDTH(8), .MAX_BEATS(256)) dut (
    .ACLK(clk), .ARESET(rst),
    .m0_AWVALID(av[0]), .m1_AWVALID(av[1]),
    .m0_AWREADY(aw_rdy[0]), .m1_AWREADY(aw_rdy[1]),
    .m0_AWID(aid[0]), .m1_AWID(aid[1]),
    .m0_WVALID(wv[0]), .m1_WVALID(wv[1]),
    .m0_WLAST(wl[0]), .m1_WLAST(wl[1]),
    .m0_WREADY(w_rdy[0]), .m1_WREADY(w_rdy[1]),
    .m0_BVALID(b_vld[0]), .m1_BVALID(b_vld[1]),
    .m0_BREADY(br[0]), .m1_BREADY(br[1]),
    .s_AWVALID(s_awvalid), .s_AWREADY(s_awready),
    .s_WVALID(s_wvalid), .s_WLAST(s_wlast), .s_WREADY(s_wready),
    .s_BVALID(s_bvalid), .s_BID(s_bid), .s_BREADY(s_bready),
    .grant(grant), .busy(busy), .beat_cnt(beat_cnt)
  );

  typedef struct { int kind; int val; } exp_t;  // kind: 0 grant, 1 beat_cnt, 2 B master
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   wtoggle = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic sb_pop(input int kind, input int act, input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event value %0d, scoreboard empty", nm, act);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk(nm, act, e.val);
    end
  endtask

  task automatic push_burst(input int g, input int n, input int m);
    sbq.push_back('{0, g});
    for (int i = 1; i <= n; i++) sbq.push_back('{1, i});
    sbq.push_back('{2, m});
  endtask

  // Monitor: compares DUT events against the scoreboard, plus per-cycle gating rules.
  int   cyc = 0;
  int   last_b_cyc = 0;
  bit   gap_armed = 1'b0;
  bit   w_hs_prev = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_grant = 2'b00;
      w_hs_prev  = 1'b0;
      gap_armed  = 1'b0;
    end else begin
      chk("gate_m0", int'((aw_rdy[0] | w_rdy[0] | b_vld[0]) && grant != 2'b01), 0);
      chk("gate_m1", int'((aw_rdy[1] | w_rdy[1] | b_vld[1]) && grant != 2'b10), 0);
      if (w_hs_prev) sb_pop(1, int'(beat_cnt), "beat_cnt");
      if (grant != prev_grant && grant != 2'b00) begin
        sb_pop(0, int'(grant), "grant");
        if (gap_armed) chk("grant_gap", cyc - last_b_cyc, 2);
        gap_armed = 1'b0;
      end
      if ((b_vld[0] & br[0]) | (b_vld[1] & br[1])) begin
        sb_pop(2, b_vld[1] ? 1 : 0, "b_master");
        last_b_cyc = cyc;
        gap_armed  = av[0] | av[1];
      end
      w_hs_prev  = (w_rdy[0] & wv[0]) | (w_rdy[1] & wv[1]);
      prev_grant = grant;
    end
  end

  // Downstream slave: BVALID after the WLAST handshake, held until BREADY.
  initial begin
    bit aw_hs, wl_hs, b_hs;
    logic [7:0] bid_n;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    s_bvalid  = 1'b0;
    s_bid     = 8'h00;
    bid_n     = 8'h00;
    forever begin
      @(negedge clk);
      aw_hs = s_awvalid & s_awready;
      wl_hs = s_wvalid & s_wready & s_wlast;
      b_hs  = s_bvalid & s_bready;
      if (aw_hs) bid_n = grant[1] ? aid[1] : aid[0];
      @(posedge clk);
      #1;
      if (aw_hs) s_bid = bid_n;
      if (b_hs || rst) s_bvalid = 1'b0;
      if (wl_hs && !rst) s_bvalid = 1'b1;
      s_wready = wtoggle ? ~s_wready : 1'b1;
    end
  end

  task automatic do_aw(input int m, input logic [7:0] id);
    bit hs = 1'b0;
    av[m]  = 1'b1;
    aid[m] = id;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = aw_rdy[m];
      @(posedge clk);
      #1;
    end
    av[m] = 1'b0;
    if (!hs) timeout("aw_wait");
  endtask

  task automatic w_beats(input int m, input int n, input bit last);
    bit hs;
    for (int i = 0; i < n; i++) begin
      wv[m] = 1'b1;
      wl[m] = last && (i == n - 1);
      hs = 1'b0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk);
        hs = w_rdy[m];
        @(posedge clk);
        #1;
      end
      if (!hs) timeout("w_wait");
    end
    wv[m] = 1'b0;
    wl[m] = 1'b0;
  endtask

  task automatic b_resp(input int m, input int hold);
    bit seen = 1'b0;
    br[m] = (hold == 0);
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = b_vld[m];
      if (!seen) begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) timeout("b_wait");
    if (hold > 0) begin
      @(posedge clk);
      #1;
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        chk("b_hold_grant", int'(grant), (m == 1) ? 2 : 1);
        chk("b_hold_bvalid", int'(b_vld[m]), 1);
        @(posedge clk);
        #1;
      end
      br[m] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    br[m] = 1'b0;
  endtask

  task automatic burst(input int m, input logic [7:0] id, input int n, input int hold);
    do_aw(m, id);
    w_beats(m, n, 1'b1);
    b_resp(m, hold);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b0; aid[i] = 8'h00; wv[i] = 1'b0; wl[i] = 1'b0; br[i] = 1'b0;
    end
    #2;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_beat", int'(beat_cnt), 0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(2);

    // Simultaneous requests: m0 two bursts, m1 one burst.
`ifdef AXI_ARB_RR_EN
    push_burst(1, 1, 0);
    push_burst(2, 2, 1);
    push_burst(1, 1, 0);
`else
    push_burst(1, 1, 0);
    push_burst(1, 1, 0);
    push_burst(2, 2, 1);
`endif
    fork
      begin
        burst(0, 8'h10, 1, 0);
        burst(0, 8'h11, 1, 0);
      end
      burst(1, 8'h20, 2, 0);
    join
    idle_cycles(2);

    // m1 presents W data two cycles before AW; it must stall, not be accepted.
    push_burst(2, 3, 1);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("w_early_ready", int'(w_rdy[1]), 0);
          @(posedge clk);
          #1;
        end
        do_aw(1, 8'h21);
      end
      w_beats(1, 3, 1'b1);
    join
    b_resp(1, 0);
    idle_cycles(2);

    // 8-beat m1 burst with s_WREADY toggling while m0 holds WVALID.
    push_burst(2, 8, 1);
    wv[0] = 1'b1;
    wtoggle = 1'b1;
    burst(1, 8'h22, 8, 0);
    wtoggle = 1'b0;
    wv[0] = 1'b0;
    idle_cycles(2);

    // m0 holds BREADY low for 3 cycles while m1 requests.
    push_burst(1, 2, 0);
    push_burst(2, 1, 1);
    fork
      burst(0, 8'h12, 2, 3);
      begin
        idle_cycles(3);
        burst(1, 8'h23, 1, 0);
      end
    join
    idle_cycles(2);

    // Single m0 burst with grant latency and return-to-idle checks.
    push_burst(1, 4, 0);
    av[0] = 1'b1;
    aid[0] = 8'h13;
    @(negedge clk);
    chk("lat_pre_grant", int'(grant), 0);
    chk("lat_pre_awvalid", int'(s_awvalid), 0);
    @(posedge clk);
    #1;
    burst(0, 8'h13, 4, 0);
    chk("end_grant", int'(grant), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_beat", int'(beat_cnt), 0);
    idle_cycles(2);

    // Reset pulsed in W after beat 3 of an m0 burst.
    sbq.push_back('{0, 1});
    sbq.push_back('{1, 1});
    sbq.push_back('{1, 2});
    sbq.push_back('{1, 3});
    do_aw(0, 8'h14);
    w_beats(0, 3, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_beat", int'(beat_cnt), 0);
    chk("arst_handshakes", int'({s_awvalid, s_wvalid, s_wlast, s_bready, aw_rdy[0], aw_rdy[1],
                                 w_rdy[0], w_rdy[1], b_vld[0], b_vld[1]}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);
    push_burst(1, 1, 0);
    push_burst(2, 1, 1);
    fork
      burst(0, 8'h15, 1, 0);
      burst(1, 8'h24, 1, 0);
    join
    idle_cycles(3);

    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
